// File: rtl/seq_ram_loader_if.sv
// Bus between fifo_rx, the sequence loader and the NW sequence RAMs.
// master = loader side, slave = FIFO/RAM/control side.
interface seq_ram_loader_if #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_W    = 8
);
  logic [DATA_SIZE-1:0] fifo_data;
  logic                 fifo_empty;
  logic                 rd_from_fifo;
  logic                 start;
  logic                 ram_we_a;
  logic                 ram_we_b;
  logic [ADDR_W-1:0]    ram_addr;
  logic [1:0]           ram_din;
  logic [ADDR_W:0]      len_a;
  logic [ADDR_W:0]      len_b;
  logic                 done;
  logic                 err_char;
  logic                 err_ovf;

  modport master (
    input  fifo_data, fifo_empty, start,
    output rd_from_fifo, ram_we_a, ram_we_b, ram_addr, ram_din,
           len_a, len_b, done, err_char, err_ovf
  );

  modport slave (
    output fifo_data, fifo_empty, start,
    input  rd_from_fifo, ram_we_a, ram_we_b, ram_addr, ram_din,
           len_a, len_b, done, err_char, err_ovf
  );
endinterface

// File: rtl/seq_ram_loader.sv
// Drains fifo_rx and writes two 2-bit-encoded nucleotide sequences into RAM A / RAM B.
// Optional macro SEQ_LOADER_LOWERCASE_EN: accept a/c/g/t as bases.
module seq_ram_loader #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  seq_ram_loader_if.master  bus
);
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [DATA_SIZE-1:0] CH_A  = DATA_SIZE'(8'h41);
  localparam logic [DATA_SIZE-1:0] CH_C  = DATA_SIZE'(8'h43);
  localparam logic [DATA_SIZE-1:0] CH_G  = DATA_SIZE'(8'h47);
  localparam logic [DATA_SIZE-1:0] CH_T  = DATA_SIZE'(8'h54);
  localparam logic [DATA_SIZE-1:0] CH_LA = DATA_SIZE'(8'h61);
  localparam logic [DATA_SIZE-1:0] CH_LC = DATA_SIZE'(8'h63);
  localparam logic [DATA_SIZE-1:0] CH_LG = DATA_SIZE'(8'h67);
  localparam logic [DATA_SIZE-1:0] CH_LT = DATA_SIZE'(8'h74);
  localparam logic [DATA_SIZE-1:0] CH_CR = DATA_SIZE'(8'h0D);
  localparam logic [DATA_SIZE-1:0] CH_LF = DATA_SIZE'(8'h0A);

  typedef enum logic [2:0] {FETCH_A, DEC_A, FETCH_B, DEC_B, DONE} state_t;

  state_t               state;
  logic [DATA_SIZE-1:0] byte_q;
  logic                 we_a_q, we_b_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [1:0]           din_q;
  logic [ADDR_W:0]      len_a_q, len_b_q;
  logic                 done_q, err_char_q, err_ovf_q;

  logic                 is_base, is_term, dec_b;
  logic [1:0]           code;
  logic [ADDR_W:0]      cur_len;

  always_comb begin
    is_base = 1'b1;
    code    = 2'd0;
    case (byte_q)
      CH_A: code = 2'd0;
      CH_C: code = 2'd1;
      CH_G: code = 2'd2;
      CH_T: code = 2'd3;
`ifdef SEQ_LOADER_LOWERCASE_EN
      CH_LA: code = 2'd0;
      CH_LC: code = 2'd1;
      CH_LG: code = 2'd2;
      CH_LT: code = 2'd3;
`else
      CH_LA, CH_LC, CH_LG, CH_LT: is_base = 1'b0;
`endif
      default: is_base = 1'b0;
    endcase
  end

  assign is_term = (byte_q == CH_CR) || (byte_q == CH_LF);
  assign dec_b   = (state == DEC_B);
  assign cur_len = dec_b ? len_b_q : len_a_q;

  // Pop only from FETCH states, so pops are at least two cycles apart.
  assign bus.rd_from_fifo = !rst && !bus.fifo_empty &&
                            ((state == FETCH_A) || (state == FETCH_B));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH_A;
      byte_q     <= '0;
      we_a_q     <= 1'b0;
      we_b_q     <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      len_a_q    <= '0;
      len_b_q    <= '0;
      done_q     <= 1'b0;
      err_char_q <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      we_a_q <= 1'b0;
      we_b_q <= 1'b0;
      case (state)
        FETCH_A, FETCH_B: begin
          if (!bus.fifo_empty) begin
            byte_q <= bus.fifo_data;
            state  <= (state == FETCH_A) ? DEC_A : DEC_B;
          end
        end
        DEC_A, DEC_B: begin
          state <= dec_b ? FETCH_B : FETCH_A;
          if (is_base) begin
            // Saturated length means RAM full: drop the base, never wrap the address.
            if (cur_len != MAX_LEN) begin
              we_a_q <= !dec_b;
              we_b_q <= dec_b;
              addr_q <= cur_len[ADDR_W-1:0];
              din_q  <= code;
              if (dec_b) len_b_q <= len_b_q + 1'b1;
              else       len_a_q <= len_a_q + 1'b1;
            end else begin
              err_ovf_q <= 1'b1;
            end
          end else if (is_term) begin
            if (cur_len != '0) begin
              if (dec_b) begin
                state  <= DONE;
                done_q <= 1'b1;
              end else begin
                state  <= FETCH_B;
              end
            end
          end else begin
            err_char_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.start) begin
            state      <= FETCH_A;
            done_q     <= 1'b0;
            len_a_q    <= '0;
            len_b_q    <= '0;
            err_char_q <= 1'b0;
            err_ovf_q  <= 1'b0;
          end
        end
        default: state <= FETCH_A;
      endcase
    end
  end

  assign bus.ram_we_a = we_a_q;
  assign bus.ram_we_b = we_b_q;
  assign bus.ram_addr = addr_q;
  assign bus.ram_din  = din_q;
  assign bus.len_a    = len_a_q;
  assign bus.len_b    = len_b_q;
  assign bus.done     = done_q;
  assign bus.err_char = err_char_q;
  assign bus.err_ovf  = err_ovf_q;
endmodule

// File: tb/tb_seq_ram_loader.sv
// Scoreboard bench for seq_ram_loader: byte-stream reference model + FWFT FIFO model.
module tb_seq_ram_loader;
  localparam int DS   = 8;
  localparam int AW   = 3;
  localparam int MAXL = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_ram_loader_if #(.DATA_SIZE(DS), .ADDR_W(AW)) bus ();
  seq_ram_loader #(.DATA_SIZE(DS), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { int seq; int addr; int din; } wr_t;

  logic [7:0] fifo_q[$];
  wr_t        sb[$];
  logic [7:0] held[$];
  int checks = 0, errors = 0;
  int dut_pops = 0;
  bit pop_req = 0;
  bit rd_d1 = 0, rd_d2 = 0;

  // reference model state: phase 0 = loading A, 1 = loading B, 2 = done
  int m_phase, m_pops;
  int m_len[2];
  bit m_ec, m_eo;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void fifo_upd();
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endfunction

  // 0..3 = base code, 4 = line terminator, 5 = anything else
  function automatic int classify(logic [7:0] b);
    string up = "ACGT";
    string lo = "acgt";
    for (int i = 0; i < 4; i++) begin
      if (b == up[i]) return i;
`ifdef SEQ_LOADER_LOWERCASE_EN
      if (b == lo[i]) return i;
`endif
    end
    if (b == 8'h0D || b == 8'h0A) return 4;
    return 5;
  endfunction

  function automatic void model_clear();
    m_phase = 0; m_len[0] = 0; m_len[1] = 0; m_ec = 0; m_eo = 0;
  endfunction

  function automatic void model_feed(logic [7:0] b);
    int k;
    wr_t w;
    if (m_phase == 2) begin
      held.push_back(b);
      return;
    end
    m_pops++;
    k = classify(b);
    if (k < 4) begin
      if (m_len[m_phase] < MAXL) begin
        w.seq = m_phase; w.addr = m_len[m_phase]; w.din = k;
        sb.push_back(w);
        m_len[m_phase]++;
      end else m_eo = 1;
    end else if (k == 4) begin
      if (m_len[m_phase] > 0) m_phase++;
    end else m_ec = 1;
  endfunction

  task automatic push_byte(logic [7:0] b);
    model_feed(b);
    @(posedge clk); #2;
    fifo_q.push_back(b);
    fifo_upd();
  endtask

  task automatic push_str(string s, int gap);
    for (int i = 0; i < s.len(); i++) begin
      push_byte(s[i]);
      repeat (gap) @(posedge clk);
    end
  endtask

  task automatic do_start();
    logic [7:0] h[$];
    @(posedge clk); #2 bus.start = 1'b1;
    @(posedge clk); #2 bus.start = 1'b0;
    if (m_phase == 2) begin
      model_clear();
      h = held; held.delete();
      foreach (h[i]) model_feed(h[i]);
    end
  endtask

  task automatic check_idle_outputs(string tag);
    chk({tag, "_rd"},       bus.rd_from_fifo, 0);
    chk({tag, "_we_a"},     bus.ram_we_a, 0);
    chk({tag, "_we_b"},     bus.ram_we_b, 0);
    chk({tag, "_addr"},     bus.ram_addr, 0);
    chk({tag, "_din"},      bus.ram_din, 0);
    chk({tag, "_len_a"},    bus.len_a, 0);
    chk({tag, "_len_b"},    bus.len_b, 0);
    chk({tag, "_done"},     bus.done, 0);
    chk({tag, "_err_char"}, bus.err_char, 0);
    chk({tag, "_err_ovf"},  bus.err_ovf, 0);
  endtask

  task automatic do_reset(string tag);
    #2 rst = 1'b1;
    fifo_q.delete(); held.delete(); sb.delete();
    fifo_upd();
    model_clear();
    m_pops = 0; dut_pops = 0;
    @(negedge clk);
    check_idle_outputs(tag);
    @(posedge clk); #2 rst = 1'b0;
  endtask

  task automatic settle(string tag);
    int n = 0;
    if (m_phase == 2) begin
      while (!bus.done && n < 3000) begin @(posedge clk); n++; end
      if (n >= 3000) chk({tag, "_done_timeout"}, bus.done, 1);
    end else begin
      while (fifo_q.size() != 0 && n < 3000) begin @(posedge clk); n++; end
      if (n >= 3000) chk({tag, "_drain_timeout"}, fifo_q.size(), 0);
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk({tag, "_len_a"},    bus.len_a, m_len[0]);
    chk({tag, "_len_b"},    bus.len_b, m_len[1]);
    chk({tag, "_err_char"}, bus.err_char, m_ec);
    chk({tag, "_err_ovf"},  bus.err_ovf, m_eo);
    chk({tag, "_done"},     bus.done, (m_phase == 2));
    chk({tag, "_pops"},     dut_pops, m_pops);
    chk({tag, "_sb_left"},  sb.size(), 0);
    chk({tag, "_fifo_left"}, fifo_q.size(), held.size());
  endtask

  task automatic rand_stream();
    string bases = "ACGT";
    logic [7:0] j;
    for (int s = 0; s < 2; s++) begin
      repeat ($urandom_range(0, 2)) push_byte($urandom_range(0, 1) ? 8'h0D : 8'h0A);
      repeat ($urandom_range(1, 11)) begin
        if ($urandom_range(0, 7) == 0) begin
          do j = 8'($urandom_range(0, 255)); while (classify(j) != 5);
          push_byte(j);
        end
        push_byte(bases[$urandom_range(0, 3)]);
      end
      if ($urandom_range(0, 1) != 0) push_byte(8'h0D);
      push_byte(8'h0A);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    fifo_upd();
    model_clear();
    m_pops = 0;

    // FIFO pop side: pops a byte one step after the edge that consumed it.
    fork
      forever begin
        @(posedge clk); #1;
        if (pop_req && fifo_q.size() != 0) void'(fifo_q.pop_front());
        fifo_upd();
      end
    join_none

    // Monitor: protocol checks and scoreboard compare on each write pulse.
    fork
      forever begin
        wr_t e;
        @(negedge clk);
        if (rst) begin
          pop_req = 0; rd_d1 = 0; rd_d2 = 0;
        end else begin
          if (bus.rd_from_fifo) begin
            chk("pop_while_empty", bus.fifo_empty, 0);
            chk("pop_spacing", rd_d1, 0);
            dut_pops++;
          end
          if (bus.ram_we_a || bus.ram_we_b) begin
            chk("we_exclusive", bus.ram_we_a && bus.ram_we_b, 0);
            chk("wr_latency", rd_d2, 1);
            chk("wr_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
              e = sb.pop_front();
              chk("wr_ram_sel", bus.ram_we_b, e.seq);
              chk("wr_addr", bus.ram_addr, e.addr);
              chk("wr_din", bus.ram_din, e.din);
            end
          end
          pop_req = bus.rd_from_fifo;
          rd_d2 = rd_d1;
          rd_d1 = bus.rd_from_fifo;
        end
      end
    join_none

    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #2 rst = 1'b0;

    push_str("ACGT\nTTA\n", 0);
    settle("basic");
    chk("basic_pops9", dut_pops, 9);

    do_start(); m_pops = 0; dut_pops = 0;
    push_str("\r\nG\r\nC\n", 0);
    settle("lead_term");

    do_start();
    push_str("AXG\nC\n", 0);
    settle("bad_char");

    do_start();
    push_str("ACGTACGTAC\nG\n", 0);
    settle("overflow");

    do_start();
    push_str("GATTACA\nCAT\n", 20);
    settle("gapped");

    do_start();
    push_str("acg\nt\n", 0);
    settle("lower");
    if (m_phase != 2) begin
      push_str("A\nC\n", 0);
      settle("lower_finish");
    end

    do_start();
    push_str("TG\nA\r\nCC", 0);
    settle("trailing_held");
    do_start();
    push_str("\n", 0);
    settle("held_drain");

    for (int r = 0; r < 8; r++) begin
      do_start();
      rand_stream();
      settle("rand");
    end

    do_start();
    push_str("ACGTAC", 0);
    repeat (3) @(posedge clk);
    do_reset("mid_reset");
    push_str("T\nG\n", 0);
    settle("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
